// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep sequencer and its bounce counter core.
package sweep_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/bounce_counter_core.sv
// Bounded up/down counter: loads a start value, steps on request and reverses
// direction when a step lands on either limit.
module bounce_counter_core
    import sweep_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] upper,
    output logic [WIDTH-1:0] count,
    output logic             dir_up,
    output logic             near_lower
);

    logic [WIDTH-1:0] r_count;
    logic             r_dir_up;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    assign w_inc = r_count + WIDTH'(1);
    assign w_dec = r_count - WIDTH'(1);

    // High when the next down-step lands on the lower limit and closes a sweep.
    assign near_lower = (r_dir_up == DIR_DOWN) && (w_dec == lower);

    // Count and direction: load wins over step, direction flips on the step that reaches a limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= '0;
            r_dir_up <= DIR_UP;
        end else if (load) begin
            r_count  <= load_value;
            r_dir_up <= DIR_UP;
        end else if (step) begin
            if (r_dir_up == DIR_UP) begin
                r_count  <= w_inc;
                r_dir_up <= (w_inc == upper) ? DIR_DOWN : DIR_UP;
            end else begin
                r_count  <= w_dec;
                r_dir_up <= (w_dec == lower) ? DIR_UP : DIR_DOWN;
            end
        end else begin
            r_count  <= r_count;
            r_dir_up <= r_dir_up;
        end
    end

    assign count  = r_count;
    assign dir_up = r_dir_up;

endmodule

// File: rtl/sweep_sequencer.sv
// Runs a bounce counter through a programmed number of lower->upper->lower sweeps,
// paced by a prescaler. Optional PAUSE_EN adds a pause input that freezes the run.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 4,
    parameter int DIV     = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
`ifdef PAUSE_EN
    input  logic               pause,
`endif
    input  logic [WIDTH-1:0]   lower,
    input  logic [WIDTH-1:0]   upper,
    input  logic [SWEEP_W-1:0] n_sweeps,
    output logic [WIDTH-1:0]   count,
    output logic               dir_up,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               cfg_error,
    output logic [SWEEP_W-1:0] sweeps_done
);

    localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_lower;
    logic [WIDTH-1:0]   r_upper;
    logic [SWEEP_W-1:0] r_n_sweeps;
    logic [SWEEP_W-1:0] r_sweeps;
    logic [PW-1:0]      r_presc;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;
    logic               r_cfg_error;

    logic               w_pause;
    logic               w_cfg_ok;
    logic               w_accept;
    logic               w_reject;
    logic               w_abort;
    logic               w_step;
    logic               w_sweep_end;
    logic               w_finish;
    logic               w_near_lower;
    logic [SWEEP_W-1:0] w_sweeps_inc;

`ifdef PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_cfg_ok     = (lower < upper);
    assign w_sweeps_inc = r_sweeps + SWEEP_W'(1);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_abort || w_finish) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-cycle decisions; stop outranks pause, pause outranks a step.
    always_comb begin
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_abort     = 1'b0;
        w_step      = 1'b0;
        w_sweep_end = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = w_cfg_ok;
                    w_reject = !w_cfg_ok;
                end else begin
                    w_accept = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    w_abort = 1'b1;
                end else if (!w_pause && (r_presc == PRESC_LAST)) begin
                    w_step      = 1'b1;
                    w_sweep_end = w_near_lower;
                    w_finish    = w_near_lower && (r_n_sweeps != '0) && (w_sweeps_inc == r_n_sweeps);
                end else begin
                    w_step = 1'b0;
                end
            end
            default: w_step = 1'b0;
        endcase
    end

    // Run configuration, prescaler, sweep counter and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lower     <= '0;
            r_upper     <= '0;
            r_n_sweeps  <= '0;
            r_sweeps    <= '0;
            r_presc     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_cfg_error <= 1'b0;
        end else begin
            r_done      <= w_finish;
            r_aborted   <= w_abort;
            r_cfg_error <= w_reject;
            if (w_accept) begin
                r_lower    <= lower;
                r_upper    <= upper;
                r_n_sweeps <= n_sweeps;
                r_sweeps   <= '0;
                r_presc    <= '0;
                r_busy     <= 1'b1;
            end else if (w_abort) begin
                r_busy <= 1'b0;
            end else if ((r_state == RUN) && !w_pause) begin
                r_presc <= w_step ? '0 : (r_presc + PW'(1));
                if (w_sweep_end) begin
                    r_sweeps <= w_sweeps_inc;
                end else begin
                    r_sweeps <= r_sweeps;
                end
                if (w_finish) begin
                    r_busy <= 1'b0;
                end else begin
                    r_busy <= r_busy;
                end
            end else begin
                r_presc <= r_presc;
            end
        end
    end

    bounce_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .load       (w_accept),
        .load_value (lower),
        .step       (w_step),
        .lower      (r_lower),
        .upper      (r_upper),
        .count      (count),
        .dir_up     (dir_up),
        .near_lower (w_near_lower)
    );

    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign cfg_error   = r_cfg_error;
    assign sweeps_done = r_sweeps;

endmodule
